// File: rtl/imem_loader.sv
// Instruction memory write side: loads a program from a serial byte stream,
// holds the core in reset while loading, and serves 32-bit fetches combinationally.
module imem_loader #(
    parameter int          DEPTH_BYTES = 64,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [7:0]                   ld_byte,
    input  logic                         ld_last,
    input  logic                         ld_restart,
    input  logic [31:0]                  fetch_addr,
    output logic [31:0]                  fetch_inst,
    output logic                         cpu_hold,
    output logic                         load_done,
    output logic [$clog2(DEPTH_BYTES):0] byte_count,
    output logic                         err_overflow
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count_nxt;
    logic            err_nxt;
    logic            accept;
    logic            full;
    logic            wr_en;
    logic [7:0]      mem [DEPTH_BYTES];

    assign ld_ready  = (state != DONE);
    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        count_nxt = byte_count;
        err_nxt   = err_overflow;
        wr_en     = 1'b0;
        accept    = ld_valid && ld_ready;
        full      = (byte_count == CW'(DEPTH_BYTES));
        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    // A byte arriving with memory full is dropped but still counts for ld_last
                    if (!full) begin
                        wr_en     = 1'b1;
                        count_nxt = byte_count + CW'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = ld_last ? DONE : LOAD;
                end
            end
            DONE: begin
                if (ld_restart) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            byte_count   <= count_nxt;
            err_overflow <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[byte_count[AW-1:0]] <= ld_byte;
    end

    // Aligned word read; address bits above the memory size wrap
    logic [AW-3:0] word_idx;
    logic [CW-1:0] word_top;
    logic          word_ok;
    logic          fetch_unused;

    assign word_idx     = fetch_addr[AW-1:2];
    assign word_top     = {1'b0, word_idx, 2'b11};
    assign word_ok      = (word_top < byte_count);
    assign fetch_unused = ^{fetch_addr[31:AW], fetch_addr[1:0]};

    always_comb begin
        fetch_inst = NOP_INST;
        if (!cpu_hold && word_ok)
            fetch_inst = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                          mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vectors, hand-written corner
// sequences and randomized loads checked against a byte-array reference model.
module tb_imem_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_restart;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic        cpu_hold;
    logic        load_done;
    logic [6:0]  byte_count;
    logic        err_overflow;

    imem_loader #(.DEPTH_BYTES(DEPTH), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_restart   (ld_restart),
        .fetch_addr   (fetch_addr),
        .fetch_inst   (fetch_inst),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .byte_count   (byte_count),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: what has been stored, how much, and whether loading finished
    logic [7:0] m_mem [DEPTH];
    int         m_cnt  = 0;
    bit         m_done = 1'b0;
    bit         m_err  = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } fvec_t;

    function automatic logic [31:0] m_fetch(input logic [31:0] a);
        int w;
        w = int'(a % 32'(DEPTH)) / 4;
        if (!m_done || (4 * w + 3) >= m_cnt) return NOP;
        return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".byte_count"}, 32'(byte_count), 32'(m_cnt));
        chk({tag, ".cpu_hold"},   32'(cpu_hold),   32'(!m_done));
        chk({tag, ".load_done"},  32'(load_done),  32'(m_done));
        chk({tag, ".ld_ready"},   32'(ld_ready),   32'(!m_done));
        chk({tag, ".err"},        32'(err_overflow), 32'(m_err));
        chk({tag, ".fetch"},      fetch_inst,      m_fetch(fetch_addr));
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later
    task automatic step(input logic v, input logic [7:0] b, input logic l,
                        input logic rs, input logic rst, input logic [31:0] fa,
                        input string tag);
        ld_valid = v; ld_byte = b; ld_last = l; ld_restart = rs;
        reset = rst; fetch_addr = fa;
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_done = 1'b0; m_err = 1'b0;
        end else if (m_done) begin
            if (rs) begin
                m_cnt = 0; m_done = 1'b0; m_err = 1'b0;
            end
        end else if (v) begin
            if (m_cnt < DEPTH) begin
                m_mem[m_cnt] = b;
                m_cnt++;
            end else begin
                m_err = 1'b1;
            end
            if (l) m_done = 1'b1;
        end
        #1;
        ld_valid = 1'b0; ld_restart = 1'b0; reset = 1'b0;
        check_all(tag);
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        fetch_addr = a;
        #1;
        chk(name, fetch_inst, exp);
    endtask

    logic [7:0] prog [16] = '{8'h03, 8'h00, 8'hc4, 8'hff, 8'h23, 8'ha4, 8'h64, 8'h00,
                              8'h33, 8'he2, 8'h62, 8'h00, 8'he3, 8'h0a, 8'h42, 8'hfe};
    fvec_t      ftab [8];

    initial begin
        ftab[0] = '{32'h0000_0000, 32'hffc40003};
        ftab[1] = '{32'h0000_0004, 32'h0064a423};
        ftab[2] = '{32'h0000_0008, 32'h0062e233};
        ftab[3] = '{32'h0000_000c, 32'hfe420ae3};
        ftab[4] = '{32'h0000_0002, 32'hffc40003};
        ftab[5] = '{32'h0000_0041, 32'hffc40003};
        ftab[6] = '{32'h0000_0010, NOP};
        ftab[7] = '{32'h1000_000f, 32'hfe420ae3};

        ld_valid = 0; ld_byte = 0; ld_last = 0; ld_restart = 0; fetch_addr = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0, "reset");
        chk("reset.byte_count", 32'(byte_count), 32'd0);
        chk("reset.cpu_hold", 32'(cpu_hold), 32'd1);
        chk("reset.ld_ready", 32'(ld_ready), 32'd1);
        chk("reset.fetch", fetch_inst, NOP);

        // Contiguous 16-byte load, then the fetch table
        for (int i = 0; i < 16; i++)
            step(1'b1, prog[i], 1'b0 | (i == 15), 1'b0, 1'b0, 32'(4 * (i % 4)), "load16");
        chk("load16.byte_count", 32'(byte_count), 32'd16);
        chk("load16.cpu_hold", 32'(cpu_hold), 32'd0);
        for (int i = 0; i < 8; i++)
            fetch_chk($sformatf("tab16[%0d]", i), ftab[i].addr, ftab[i].exp);

        // Restart with ld_valid high: nothing accepted, back to IDLE
        step(1'b1, 8'haa, 1'b1, 1'b1, 1'b0, 32'h0, "restart");
        chk("restart.cpu_hold", 32'(cpu_hold), 32'd1);
        chk("restart.fetch", fetch_inst, NOP);
        chk("restart.byte_count", 32'(byte_count), 32'd0);

        // Same program with ld_valid every other cycle
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h5a, 1'b1, 1'b0, 1'b0, $urandom, "gap.idle");
            step(1'b1, prog[i], 1'b0 | (i == 15), 1'b0, 1'b0, $urandom, "gap.load");
        end
        for (int i = 0; i < 8; i++)
            fetch_chk($sformatf("tabgap[%0d]", i), ftab[i].addr, ftab[i].exp);

        // Six bytes: one whole word, one partial word
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, "restart6");
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'h11 + i), 1'b0 | (i == 5), 1'b0, 1'b0, 32'h0, "load6");
        fetch_chk("p6.word0", 32'h0, 32'h14131211);
        fetch_chk("p6.partial", 32'h4, NOP);
        fetch_chk("p6.alias", 32'h40, 32'h14131211);

        // Overflow: 66 bytes into 64
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, "restart66");
        for (int i = 0; i < 66; i++) begin
            step(1'b1, 8'(i), 1'b0 | (i == 65), 1'b0, 1'b0, 32'd60, "load66");
            if (i == 63) chk("ovf.err_before", 32'(err_overflow), 32'd0);
            if (i == 64) begin
                chk("ovf.err_after65", 32'(err_overflow), 32'd1);
                chk("ovf.count", 32'(byte_count), 32'd64);
                chk("ovf.not_done", 32'(load_done), 32'd0);
            end
        end
        chk("ovf.done", 32'(load_done), 32'd1);
        fetch_chk("ovf.lastword", 32'd60, 32'h3f3e3d3c);

        // Reset mid-load beats a same-cycle handshake; fresh load reads new data only
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, "restartR");
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'ha0 + i), 1'b0, 1'b0, 1'b0, 32'h0, "pre_reset");
        step(1'b1, 8'hee, 1'b1, 1'b0, 1'b1, 32'h0, "midreset");
        chk("midreset.count", 32'(byte_count), 32'd0);
        chk("midreset.hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'(8'hc0 + i), 1'b0 | (i == 7), 1'b0, 1'b0, 32'h4, "fresh8");
        fetch_chk("fresh.w0", 32'h0, 32'hc3c2c1c0);
        fetch_chk("fresh.w1", 32'h4, 32'hc7c6c5c4);
        fetch_chk("fresh.w2", 32'h8, NOP);

        // Randomized loads with gaps, stray restarts and occasional resets
        for (int n = 0; n < 25; n++) begin
            int len;
            len = $urandom_range(1, 70);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, $urandom, "rnd.restart");
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 2) == 0)
                    step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, $urandom, "rnd.gap");
                step(1'b1, 8'($urandom), 1'b0 | (i == len - 1), 1'($urandom),
                     ($urandom_range(0, 60) == 0), $urandom, "rnd.byte");
            end
            for (int k = 0; k < 10; k++)
                step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, $urandom, "rnd.fetch");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
